// File: rtl/crc_pkg.sv
// Shared definitions for the crc_stream slice: FSM encoding and standard CRC constants.
package crc_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } crc_state_e;

   // CRC-32/POSIX
   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   // CRC-16/XMODEM
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_XOR_OUT = 16'h0000;
   localparam logic [15:0] CRC16_RESIDUE = 16'h0000;

endpackage

// File: rtl/crc_step.sv
// Combinational next-register function: DATA_W unrolled LFSR steps applied to one input beat.
module crc_step
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W     = 32,
   parameter logic [CRC_W-1:0] POLY      = CRC32_POLY,
   parameter int unsigned      DATA_W    = 8,
   parameter bit               MSB_FIRST = 1'b1
) (
   input  logic [CRC_W-1:0]  i_crc,
   input  logic [DATA_W-1:0] i_data,
   output logic [CRC_W-1:0]  o_crc
);

   logic [CRC_W-1:0] w_acc;
   logic             w_bit;

   always_comb begin
      w_acc = i_crc;
      w_bit = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         w_bit = MSB_FIRST ? i_data[DATA_W-1-i] : i_data[i];
         w_acc = {w_acc[CRC_W-2:0], 1'b0} ^ ((w_acc[CRC_W-1] ^ w_bit) ? POLY : '0);
      end
      o_crc = w_acc;
   end

endmodule

// File: rtl/crc_stream.sv
// Beat-wide streaming CRC generator/checker with valid/ready input and held result.
// Optional saturating error counter port err_cnt_o when CRC_STREAM_ERRCNT_EN is defined.
module crc_stream
   import crc_pkg::*;
#(
   parameter int unsigned      CRC_W     = 32,
   parameter logic [CRC_W-1:0] POLY      = CRC32_POLY,
   parameter logic [CRC_W-1:0] INIT      = '0,
   parameter logic [CRC_W-1:0] XOR_OUT   = CRC32_XOR_OUT,
   parameter logic [CRC_W-1:0] RESIDUE   = CRC32_RESIDUE,
   parameter int unsigned      DATA_W    = 8,
   parameter bit               MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              clear_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_last_i,
   output logic              res_valid_o,
   input  logic              res_ack_i,
   output logic [CRC_W-1:0]  crc_o,
   output logic              match_o,
   output logic              busy_o
`ifdef CRC_STREAM_ERRCNT_EN
   ,
   output logic [15:0]       err_cnt_o
`endif
);

   crc_state_e       r_state, w_state_d;
   logic [CRC_W-1:0] r_crc, w_crc_d;
   logic [CRC_W-1:0] r_crc_out, w_crc_out_d;
   logic             r_match, w_match_d;
   logic             r_rdy;
   logic [CRC_W-1:0] w_step_in, w_step_out;
   logic             w_accept;

   // A frame's first beat always starts from INIT, regardless of what the register holds.
   assign w_step_in = (r_state == StIdle) ? INIT : r_crc;

   crc_step #(
      .CRC_W     (CRC_W),
      .POLY      (POLY),
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_step (
      .i_crc  (w_step_in),
      .i_data (s_data_i),
      .o_crc  (w_step_out)
   );

   assign s_ready_o   = r_rdy & (r_state != StDone);
   assign w_accept    = s_valid_i & s_ready_o;
   assign res_valid_o = (r_state == StDone);
   assign busy_o      = (r_state == StRun);
   assign crc_o       = r_crc_out;
   assign match_o     = r_match;

   always_comb begin
      w_state_d   = r_state;
      w_crc_d     = r_crc;
      w_crc_out_d = r_crc_out;
      w_match_d   = r_match;
      if (clear_i) begin
         w_state_d = StIdle;
         w_crc_d   = INIT;
         w_match_d = 1'b0;
      end else begin
         unique case (r_state)
            StIdle, StRun: begin
               if (w_accept) begin
                  w_crc_d = w_step_out;
                  if (s_last_i) begin
                     w_state_d   = StDone;
                     w_crc_out_d = w_step_out ^ XOR_OUT;
                     w_match_d   = (w_step_out == RESIDUE);
                  end else begin
                     w_state_d = StRun;
                  end
               end
            end
            StDone: begin
               if (res_ack_i) begin
                  w_state_d = StIdle;
                  w_crc_d   = INIT;
                  w_match_d = 1'b0;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state   <= StIdle;
         r_crc     <= INIT;
         r_crc_out <= '0;
         r_match   <= 1'b0;
         r_rdy     <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_crc     <= w_crc_d;
         r_crc_out <= w_crc_out_d;
         r_match   <= w_match_d;
         r_rdy     <= 1'b1;
      end
   end

`ifdef CRC_STREAM_ERRCNT_EN
   logic [15:0] r_err_cnt;

   // Counts frames that end without the residue; unaffected by clear_i.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_err_cnt <= 16'd0;
      end else if (!clear_i && w_accept && s_last_i && (w_step_out != RESIDUE)
                   && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Randomised self-checking bench for crc_stream against a byte-level CRC reference model.
module tb_crc_stream;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int exp_err = 0;

   // Default-configuration DUT
   logic        s_valid, s_ready, s_last, res_valid, res_ack, match, busy, clear;
   logic [7:0]  s_data;
   logic [31:0] crc;
   // Serial DUT (DATA_W=1)
   logic        ser_valid, ser_ready, ser_last, ser_res_valid, ser_ack, ser_match, ser_busy;
   logic [0:0]  ser_data;
   logic [31:0] ser_crc;
   // CRC-16/XMODEM DUT
   logic        x_valid, x_ready, x_last, x_res_valid, x_ack, x_match, x_busy;
   logic [7:0]  x_data;
   logic [15:0] x_crc;
   logic        no_clear = 1'b0;
`ifdef CRC_STREAM_ERRCNT_EN
   logic [15:0] err_cnt, ser_err, x_err;
`endif

   crc_stream u_dut (
      .clk_i(clk), .reset_ni(reset_n), .clear_i(clear), .s_valid_i(s_valid),
      .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last), .res_valid_o(res_valid),
      .res_ack_i(res_ack), .crc_o(crc), .match_o(match), .busy_o(busy)
`ifdef CRC_STREAM_ERRCNT_EN
      , .err_cnt_o(err_cnt)
`endif
   );

   crc_stream #(.DATA_W(1)) u_ser (
      .clk_i(clk), .reset_ni(reset_n), .clear_i(no_clear), .s_valid_i(ser_valid),
      .s_ready_o(ser_ready), .s_data_i(ser_data), .s_last_i(ser_last),
      .res_valid_o(ser_res_valid), .res_ack_i(ser_ack), .crc_o(ser_crc), .match_o(ser_match),
      .busy_o(ser_busy)
`ifdef CRC_STREAM_ERRCNT_EN
      , .err_cnt_o(ser_err)
`endif
   );

   crc_stream #(
      .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
   ) u_x16 (
      .clk_i(clk), .reset_ni(reset_n), .clear_i(no_clear), .s_valid_i(x_valid),
      .s_ready_o(x_ready), .s_data_i(x_data), .s_last_i(x_last), .res_valid_o(x_res_valid),
      .res_ack_i(x_ack), .crc_o(x_crc), .match_o(x_match), .busy_o(x_busy)
`ifdef CRC_STREAM_ERRCNT_EN
      , .err_cnt_o(x_err)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Plain polynomial division, one message byte at a time, MSB first; returns the raw register.
   function automatic logic [63:0] crc_model(input byte_q_t q, input int w,
                                             input logic [63:0] poly, input logic [63:0] init);
      logic [63:0] mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      logic [63:0] r = init;
      foreach (q[i]) begin
         r ^= 64'(q[i]) << (w - 8);
         for (int b = 0; b < 8; b++) r = r[w-1] ? (((r << 1) ^ poly) & mask) : ((r << 1) & mask);
      end
      return r;
   endfunction

   task automatic send_frame(input byte_q_t q, input int max_gap, input bit with_last);
      foreach (q[i]) begin
         repeat ($urandom_range(0, max_gap)) begin
            s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
            @(negedge clk);
         end
         s_valid = 1'b1; s_data = q[i]; s_last = with_last && (i == q.size() - 1);
         if (!s_ready) check("ready_in_frame", s_ready, 1);
         @(negedge clk);
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic expect_result(input string tag, input byte_q_t q);
      logic [63:0] r = crc_model(q, 32, 64'h04C11DB7, 64'h0);
      logic exp_match = (r[31:0] == 32'hC704DD7B);
      check({tag, "_valid"}, res_valid, 1);
      check({tag, "_crc"}, crc, r[31:0] ^ 32'hFFFFFFFF);
      check({tag, "_match"}, match, exp_match);
      if (!exp_match && exp_err < 65535) exp_err++;
`ifdef CRC_STREAM_ERRCNT_EN
      check({tag, "_errcnt"}, err_cnt, exp_err);
`endif
   endtask

   task automatic ack_result(input string tag);
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      check({tag, "_ack_valid"}, res_valid, 0);
      check({tag, "_ack_ready"}, s_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t kat = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      byte_q_t q;
      logic [31:0] c;
      s_valid = 0; s_data = 0; s_last = 0; res_ack = 0; clear = 0;
      ser_valid = 0; ser_data = 0; ser_last = 0; ser_ack = 0;
      x_valid = 0; x_data = 0; x_last = 0; x_ack = 0;

      // Reset state
      #3;
      check("rst_ready", s_ready, 0);
      check("rst_valid", res_valid, 0);
      check("rst_crc", crc, 0);
      check("rst_match", match, 0);
      check("rst_busy", busy, 0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", s_ready, 1);

      // Serial equivalence, DATA_W=1
      check("ser_ready", ser_ready, 1);
      foreach (kat[i]) begin
         for (int b = 7; b >= 0; b--) begin
            ser_valid = 1'b1; ser_data = kat[i][b]; ser_last = (i == 8) && (b == 0);
            @(negedge clk);
         end
         if (i == 0) check("ser_busy", ser_busy, 1);
      end
      ser_valid = 1'b0; ser_last = 1'b0;
      check("ser_valid", ser_res_valid, 1);
      check("ser_crc", ser_crc, 32'h765E7680);
      check("ser_match", ser_match, 0);
`ifdef CRC_STREAM_ERRCNT_EN
      check("ser_errcnt", ser_err, 1);
`endif
      ser_ack = 1'b1; @(negedge clk); ser_ack = 1'b0;
      check("ser_ack_valid", ser_res_valid, 0);

      // CRC-16/XMODEM
      foreach (kat[i]) begin
         x_valid = 1'b1; x_data = kat[i]; x_last = (i == 8);
         @(negedge clk);
         if (i == 0) check("x16_busy", x_busy, 1);
      end
      x_valid = 1'b0; x_last = 1'b0;
      check("x16_valid", x_res_valid, 1);
      check("x16_crc", x_crc, 16'h31C3);
      check("x16_model", x_crc, crc_model(kat, 16, 64'h1021, 64'h0));
      check("x16_match", x_match, 0);
`ifdef CRC_STREAM_ERRCNT_EN
      check("x16_errcnt", x_err, 1);
`endif
      x_ack = 1'b1; @(negedge clk); x_ack = 1'b0;
      check("x16_ready", x_ready, 1);

      // Known answer, with random gaps, then backpressure
      send_frame(kat, 2, 1'b1);
      expect_result("kat", kat);
      check("kat_const", crc, 32'h765E7680);
      s_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         s_data = 8'($urandom); s_last = 1'($urandom);
         @(negedge clk);
         check("bp_ready", s_ready, 0);
         check("bp_crc", crc, 32'h765E7680);
         check("bp_valid", res_valid, 1);
      end
      s_valid = 1'b0; s_last = 1'b0;
      ack_result("bp");

      // Back-to-back check-mode frame, then single-bit corruption
      q = kat;
      q.push_back(8'h76); q.push_back(8'h5E); q.push_back(8'h76); q.push_back(8'h80);
      send_frame(q, 0, 1'b1);
      expect_result("chk_good", q);
      check("chk_good_const", match, 1);
      ack_result("chk_good");
      q[2] ^= 8'(1 << $urandom_range(0, 7));
      send_frame(q, 1, 1'b1);
      expect_result("chk_bad", q);
      check("chk_bad_const", match, 0);
      ack_result("chk_bad");

      // Random frames, some carrying their own CRC
      for (int f = 0; f < 20; f++) begin
         q = {};
         repeat ($urandom_range(1, 12)) q.push_back(8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            c = 32'(crc_model(q, 32, 64'h04C11DB7, 64'h0)) ^ 32'hFFFFFFFF;
            for (int k = 3; k >= 0; k--) q.push_back(c[8*k +: 8]);
         end
         send_frame(q, 3, 1'b1);
         expect_result("rand", q);
         ack_result("rand");
      end

      // Abort with clear_i while a beat is presented
      q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame(q, 1, 1'b0);
      check("abort_busy_pre", busy, 1);
      s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; s_valid = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_ready", s_ready, 1);
      send_frame(kat, 1, 1'b1);
      expect_result("abort_kat", kat);
      ack_result("abort_kat");

      // Asynchronous reset mid-frame
      send_frame(q, 0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_crc", crc, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", s_ready, 0);
      check("arst_valid", res_valid, 0);
      check("arst_match", match, 0);
      exp_err = 0;
`ifdef CRC_STREAM_ERRCNT_EN
      check("arst_errcnt", err_cnt, 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("arst_ready_rel", s_ready, 1);
      send_frame(kat, 1, 1'b1);
      expect_result("arst_kat", kat);
      check("arst_kat_const", crc, 32'h765E7680);
      ack_result("arst_kat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
